// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-resource multi-cycle RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/write-back and bounds memory waits.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting, expired;

  // Only a fetch that is actually requesting memory counts as a wait state.
  assign waiting = ((state_q == FETCH) && run) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign expired = waiting && !mem_ready && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      FETCH:    if (run && mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_IMM:             state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH:          state_d = BRANCH;
          OP_JAL:             state_d = JAL;
          OP_JALR:            state_d = JALR;
          default:            state_d = FETCH;
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      MEM_ADDR: state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      default:  state_d = FETCH;
    endcase
    // A ready on the last allowed cycle never reaches here, so ready wins.
    if (expired) begin
      state_d = FETCH;
    end else if (waiting && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    state         = 4'd0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    mem_timeout   = 1'b0;
    // Reset masks every output so an interrupted write-back cannot commit.
    if (!reset) begin
      state       = state_q;
      mem_timeout = expired;
      case (state_q)
        FETCH: begin
          if (run) begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
            end
          end
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        EXEC_I, MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        WB_ALU: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        BRANCH: begin
          alu_src_a     = 2'b10;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
          instr_done    = 1'b1;
        end
        JAL: begin
          pc_write   = 1'b1;
          pc_src     = 1'b1;
          reg_write  = 1'b1;
          mem_to_reg = 2'b10;
          instr_done = 1'b1;
        end
        JALR: begin
          // PC still holds PC+4 here, so the link write sees the right value.
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b10;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          mem_to_reg = 2'b10;
          instr_done = 1'b1;
        end
        default: instr_done = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level trace model
// predicts the state walk and control word each cycle.
module tb_multicycle_ctrl;

  localparam int WAIT_LIMIT = 15;

  logic       clk = 1'b0;
  logic       reset, run, mem_ready;
  logic [6:0] opcode;
  logic       pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, instr_done, illegal, mem_timeout;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       done;
    logic       tmo;
    logic       ill;
  } step_t;

  step_t seq[$];

  multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .instr_done(instr_done), .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  logic [22:0] act;
  assign act = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                state, instr_done, illegal, mem_timeout};

  // Control word each step must show, straight from the per-state action list.
  function automatic logic [22:0] ctrl_for(input step_t e, input logic run_i);
    logic pw, pwc, ps, iod, mr, mw, irw, rw;
    logic [1:0] m2r, a, b, op;
    {pw, pwc, ps, iod, mr, mw, irw, rw} = '0;
    {m2r, a, b, op} = '0;
    case (e.st)
      4'd0: if (run_i) begin
        mr = 1; b = 2'b01;
        if (e.rdy) begin irw = 1; pw = 1; end
      end
      4'd1:  begin a = 2'b01; b = 2'b10; end
      4'd2:  begin a = 2'b10; op = 2'b10; end
      4'd3:  begin a = 2'b10; b = 2'b10; end
      4'd4:  rw = 1;
      4'd5:  begin a = 2'b10; b = 2'b10; end
      4'd6:  begin mr = 1; iod = 1; end
      4'd7:  begin rw = 1; m2r = 2'b01; end
      4'd8:  begin mw = 1; iod = 1; end
      4'd9:  begin a = 2'b10; op = 2'b01; pwc = 1; ps = 1; end
      4'd10: begin pw = 1; ps = 1; rw = 1; m2r = 2'b10; end
      4'd11: begin a = 2'b10; b = 2'b10; pw = 1; rw = 1; m2r = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, rw, m2r, a, b, op, e.st, e.done, e.ill, e.tmo};
  endfunction

  task automatic push(input int st, input bit rdy, input bit done, input bit tmo, input bit ill);
    step_t e;
    e.st = 4'(st); e.rdy = rdy; e.done = done; e.tmo = tmo; e.ill = ill;
    seq.push_back(e);
  endtask

  // Memory wait of n not-ready cycles; returns 1 if it ends in an abort.
  task automatic push_wait(input int st, input int n, output bit aborted);
    for (int i = 0; i < n && i < WAIT_LIMIT; i++)
      push(st, 0, 0, (n >= WAIT_LIMIT) && (i == WAIT_LIMIT - 1), 0);
    aborted = (n >= WAIT_LIMIT);
  endtask

  // Expected trace of one instruction given fetch and memory wait lengths.
  task automatic build(input logic [6:0] op, input int fw, input int mw);
    bit ab;
    seq.delete();
    push_wait(0, fw, ab);
    if (ab) return;
    push(0, 1, 0, 0, 0);
    case (op)
      7'b0110011: begin push(1, 0, 0, 0, 0); push(2, 0, 0, 0, 0); push(4, 0, 1, 0, 0); end
      7'b0010011: begin push(1, 0, 0, 0, 0); push(3, 0, 0, 0, 0); push(4, 0, 1, 0, 0); end
      7'b0000011: begin
        push(1, 0, 0, 0, 0); push(5, 0, 0, 0, 0);
        push_wait(6, mw, ab);
        if (!ab) begin push(6, 1, 0, 0, 0); push(7, 0, 1, 0, 0); end
      end
      7'b0100011: begin
        push(1, 0, 0, 0, 0); push(5, 0, 0, 0, 0);
        push_wait(8, mw, ab);
        if (!ab) push(8, 1, 1, 0, 0);
      end
      7'b1100011: begin push(1, 0, 0, 0, 0); push(9, 0, 1, 0, 0); end
      7'b1101111: begin push(1, 0, 0, 0, 0); push(10, 0, 1, 0, 0); end
      7'b1100111: begin push(1, 0, 0, 0, 0); push(11, 0, 1, 0, 0); end
      default:    push(1, 0, 0, 0, 1);
    endcase
  endtask

  task automatic check_output(input string name, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst_i, input logic run_i, input logic [6:0] op, input logic rdy);
    @(negedge clk);
    reset = rst_i; run = run_i; opcode = op; mem_ready = rdy;
    #2;
  endtask

  task automatic idle(input string name, input int n);
    step_t e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      apply_stimulus(0, 0, 7'b0110011, 1);
      check_output(name, act, ctrl_for(e, 0));
    end
  endtask

  // Plays one instruction; exp_cycles < 0 skips the latency check, abort_at >= 0 resets there.
  task automatic run_instr(input string name, input logic [6:0] op, input int fw, input int mw,
                           input int exp_cycles, input int exp_rw, input int abort_at);
    int cyc, rw;
    cyc = -1; rw = 0;
    build(op, fw, mw);
    for (int k = 0; k < seq.size(); k++) begin
      apply_stimulus(k == abort_at, 1, op, seq[k].rdy);
      if (k == abort_at) begin
        check_output({name, "_reset"}, act, 23'd0);
        rw += int'(reg_write);
        break;
      end
      check_output(name, act, ctrl_for(seq[k], 1));
      rw += int'(reg_write);
      if (cyc < 0 && (instr_done || illegal || mem_timeout)) cyc = k + 1;
    end
    if (exp_cycles >= 0) check_count({name, "_cycles"}, cyc, exp_cycles);
    check_count({name, "_reg_writes"}, rw, exp_rw);
  endtask

  initial begin
    reset = 1; run = 0; opcode = 7'd0; mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 1, 7'b0110011, 1);
      check_output("reset_hold", act, 23'd0);
    end
    run_instr("rtype",      7'b0110011, 0, 0, 4, 1, -1);
    run_instr("opimm",      7'b0010011, 0, 0, 4, 1, -1);
    run_instr("load",       7'b0000011, 0, 0, 5, 1, -1);
    run_instr("load_wait3", 7'b0000011, 0, 3, 8, 1, -1);
    run_instr("store",      7'b0100011, 0, 0, 4, 0, -1);
    run_instr("store_tmo",  7'b0100011, 0, 99, 18, 0, -1);
    run_instr("branch",     7'b1100011, 0, 0, 3, 0, -1);
    run_instr("jal",        7'b1101111, 0, 0, 3, 1, -1);
    run_instr("jalr",       7'b1100111, 0, 0, 3, 1, -1);
    run_instr("illegal",    7'b0000000, 0, 0, 2, 0, -1);
    run_instr("illegal_ff", 7'b1111111, 0, 0, 2, 0, -1);
    run_instr("fetch_wait", 7'b0110011, 2, 0, 6, 1, -1);
    run_instr("fetch_tmo",  7'b0110011, 15, 0, 15, 0, -1);
    run_instr("load_edge",  7'b0000011, 0, 14, 19, 1, -1);
    run_instr("load_tmo",   7'b0000011, 0, 15, 18, 0, -1);
    idle("run_low", 5);
    run_instr("load_abort", 7'b0000011, 0, 0, -1, 0, 4);
    idle("after_abort", 1);
    run_instr("rtype_again", 7'b0110011, 0, 0, 4, 1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
